circuito_decodificador_funcionalidade: RTL and testbench
========================================================

Name: circuito_decodificador_funcionalidade

Overview:
- Receiving end of the 7-function encoding. Takes the 3-bit function code (F1 = MSB, F3 = LSB) and produces the seven one-hot function lines A..G.
- The code may come from switches or another clock domain. It is therefore synchronised, then qualified as stable for a programmable number of cycles, before it drives the registered one-hot outputs.
- Sits between the encoder/switch bank and the functional datapath; gives that datapath glitch-free, debounced selection lines.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronised samples required to accept a new code; legal range 2..(2**CNT_W - 1).
- CNT_W, 4: qualification counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- F1  input  1  code bit 2 (MSB), asynchronous
- F2  input  1  code bit 1, asynchronous
- F3  input  1  code bit 0 (LSB), asynchronous
- CLR  input  1  synchronous clear of held selection; used only with the macro
- A..G  output  1 each  one-hot function lines: code 1 gives A, 2 gives B, … 7 gives G; code 0 gives all low
- VLD  output  1  high while any of A..G is high
- CHG  output  1  one-cycle pulse when the accepted code changes

Behaviour:
- Reset (async, rst=1): sync flops, candidate, accepted code and counter = 0; FSM = STABLE; A..G = 0, VLD = 0, CHG = 0.
- Input sync: two-flop synchroniser on {F1,F2,F3}; s2 is the synchronised code.
- FSM state STABLE:
  - If s2 != acc: cand <= s2, cnt <= 1, go to QUAL.
  - Otherwise stay.
- FSM state QUAL, checked in priority order:
  - s2 == acc: abort (glitch); go to STABLE, cnt <= 0, outputs unchanged.
  - s2 != cand: cand <= s2, cnt <= 1; restart qualification.
  - cnt == STABLE_CYCLES-1: acc <= cand; A..G registered one-hot of cand on the same edge; CHG <= 1 for one cycle; go to STABLE.
  - Otherwise: cnt <= cnt + 1.
- Latency: input change (held steady) to output change = STABLE_CYCLES + 2 clock edges. Default = 6.
- Outputs:
  - A..G, VLD and CHG are all flops; no combinational path from inputs.
  - At most one of A..G is high at any time.
  - VLD == (acc != 0).
- Toggling input: an input that never stays STABLE_CYCLES samples leaves the outputs untouched indefinitely.
- Reset mid-QUAL: immediate return to reset values; no CHG pulse.
- Counter: never exceeds STABLE_CYCLES-1; no wrap.

Optional Feature:
- Macro CODEC_HOLD_EN.
- Defined (hold mode):
  - A qualified code 0 is not accepted: acc keeps the last nonzero code, no CHG pulse, FSM returns to STABLE.
  - CLR=1 at an edge forces acc = 0, A..G = 0, FSM = STABLE, cnt = 0; CHG pulses only if acc was nonzero.
  - CLR wins over a commit in the same cycle.
- Undefined:
  - CLR is ignored.
  - Code 0 qualifies like any other code and clears A..G.

Decomposition:
- Shared package/include: code width (3), CODE_NONE = 3'd0, state encodings STABLE/QUAL, and the code-to-one-hot mapping function, all shared with the encoder side.
- One sub-module: sincronizador_2ff, a parameterised-width two-flop synchroniser with async active-high reset, reusable by other input blocks.

Test Plan:
- Reset, then inputs 000 → A..G = 0, VLD = 0, CHG = 0 indefinitely.
- F1F2F3 = 011 applied and held (STABLE_CYCLES=4) → C = 1, VLD = 1 on the 6th edge after the change; CHG high for exactly that one cycle.
- Code 101 pulsed for 3 cycles, then back to the accepted 011 → outputs unchanged, no CHG.
- Code toggling 110/111 every 2 cycles for 40 cycles, then held at 111 → no change during toggling; G = 1 six edges after the hold starts.
- rst asserted in the middle of qualifying 100 → outputs 0 immediately; after release with 100 still held, D = 1 within 6 edges, one CHG.
- CODEC_HOLD_EN defined: accept 010 (B), drive 000 for 20 cycles → B stays 1. Then CLR for one cycle → all 0 and one CHG. Without the macro, the same 000 gives all 0 six edges after it is applied.

Source files
------------

// File: rtl/circuito_decodificador_funcionalidade_pkg.sv
// Shared definitions for the 7-function code: code width, the "no function" code,
// FSM state encodings and the code-to-one-hot mapping used by encoder and decoder.
package circuito_decodificador_funcionalidade_pkg;

  localparam int CODE_W = 3;
  localparam int FUNC_N = 7;
  localparam logic [CODE_W-1:0] CODE_NONE = 3'd0;

  typedef enum logic {
    STABLE = 1'b0,
    QUAL   = 1'b1
  } state_t;

  // Bit 0 is function A (code 1) up to bit 6 = function G (code 7); code 0 maps to all low.
  function automatic logic [FUNC_N-1:0] code2onehot(input logic [CODE_W-1:0] code);
    logic [FUNC_N-1:0] oh;
    oh = '0;
    for (int i = 1; i <= FUNC_N; i++) begin
      if (code == CODE_W'(i)) oh[i-1] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/circuito_decodificador_funcionalidade_sincronizador_2ff.sv
// Parameterised-width two-flop synchroniser with asynchronous active-high reset,
// meant to be reused by any block that samples asynchronous inputs.
module sincronizador_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/circuito_decodificador_funcionalidade.sv
// Function-code decoder: synchronises {F1,F2,F3}, qualifies it as stable, and drives
// registered one-hot lines A..G plus VLD/CHG. Optional hold mode: macro CODEC_HOLD_EN.
module circuito_decodificador_funcionalidade
  import circuito_decodificador_funcionalidade_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic F1,
  input  logic F2,
  input  logic F3,
  input  logic CLR,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic E,
  output logic F,
  output logic G,
  output logic VLD,
  output logic CHG
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [CODE_W-1:0] w_s2;
  state_t            r_state, w_nextState;
  logic [CODE_W-1:0] r_cand, w_nextCand;
  logic [CODE_W-1:0] r_acc, w_nextAcc;
  logic [CNT_W-1:0]  r_cnt, w_nextCnt;
  logic [FUNC_N-1:0] r_oh, w_nextOh;
  logic              r_vld;
  logic              r_chg, w_nextChg;
  logic              w_accept;

  sincronizador_2ff #(.W(CODE_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({F1, F2, F3}),
    .o_q (w_s2)
  );

`ifdef CODEC_HOLD_EN
  assign w_accept = (r_cand != CODE_NONE);
`else
  logic w_unused_clr;
  assign w_unused_clr = CLR;
  assign w_accept     = 1'b1;
`endif

  always_comb begin
    w_nextState = r_state;
    w_nextCand  = r_cand;
    w_nextAcc   = r_acc;
    w_nextCnt   = r_cnt;
    w_nextOh    = r_oh;
    w_nextChg   = 1'b0;
    case (r_state)
      STABLE: begin
        if (w_s2 != r_acc) begin
          w_nextCand  = w_s2;
          w_nextCnt   = CNT_W'(1);
          w_nextState = QUAL;
        end
      end
      QUAL: begin
        // A return to the accepted code is a glitch; a different code restarts the count.
        if (w_s2 == r_acc) begin
          w_nextState = STABLE;
          w_nextCnt   = '0;
        end else if (w_s2 != r_cand) begin
          w_nextCand = w_s2;
          w_nextCnt  = CNT_W'(1);
        end else if (r_cnt == CNT_LAST) begin
          w_nextState = STABLE;
          w_nextCnt   = '0;
          if (w_accept) begin
            w_nextAcc = r_cand;
            w_nextOh  = code2onehot(r_cand);
            w_nextChg = 1'b1;
          end
        end else begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_nextState = STABLE;
        w_nextCnt   = '0;
      end
    endcase
`ifdef CODEC_HOLD_EN
    // Clearing the held selection overrides any commit happening on the same edge.
    if (CLR) begin
      w_nextAcc   = CODE_NONE;
      w_nextOh    = '0;
      w_nextState = STABLE;
      w_nextCnt   = '0;
      w_nextChg   = (r_acc != CODE_NONE);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= STABLE;
      r_cand  <= CODE_NONE;
      r_acc   <= CODE_NONE;
      r_cnt   <= '0;
      r_oh    <= '0;
      r_vld   <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cand  <= w_nextCand;
      r_acc   <= w_nextAcc;
      r_cnt   <= w_nextCnt;
      r_oh    <= w_nextOh;
      r_vld   <= (w_nextAcc != CODE_NONE);
      r_chg   <= w_nextChg;
    end
  end

  assign {G, F, E, D, C, B, A} = r_oh;
  assign VLD = r_vld;
  assign CHG = r_chg;

endmodule

// File: tb/tb_circuito_decodificador_funcionalidade.sv
// Self-checking bench for circuito_decodificador_funcionalidade: vector table with a
// scoreboard queue, plus hand sequences for latency, reset and clear/hold behaviour.
module tb_circuito_decodificador_funcionalidade;

  logic clk = 1'b0;
  logic rst;
  logic F1, F2, F3, CLR;
  logic A, B, C, D, E, F, G, VLD, CHG;
  logic [6:0] oh;

  int checks = 0;
  int errors = 0;
  int chgSeen = 0;

  localparam logic [6:0] OH_NONE = 7'b0000000;
  localparam logic [6:0] OH_A    = 7'b0000001;
  localparam logic [6:0] OH_B    = 7'b0000010;
  localparam logic [6:0] OH_C    = 7'b0000100;
  localparam logic [6:0] OH_D    = 7'b0001000;
  localparam logic [6:0] OH_G    = 7'b1000000;

  typedef struct {
    logic [2:0] code;
    int         hold;
    logic [6:0] expOh;
    logic       expVld;
    int         expChg;
  } vec_t;

  vec_t vecs[$];
  vec_t sbQ[$];

  circuito_decodificador_funcionalidade #(.STABLE_CYCLES(4), .CNT_W(4)) dut (
    .clk (clk), .rst (rst), .F1 (F1), .F2 (F2), .F3 (F3), .CLR (CLR),
    .A (A), .B (B), .C (C), .D (D), .E (E), .F (F), .G (G),
    .VLD (VLD), .CHG (CHG)
  );

  assign oh = {G, F, E, D, C, B, A};

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [2:0] code);
    {F1, F2, F3} = code;
  endtask

  // Advance one edge, sample 1 time unit later, and check the output invariants.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (CHG) chgSeen++;
    checks++;
    if ($countones(oh) > 1 || VLD != (oh != 7'b0)) begin
      errors++;
      $display("[TB] FAIL invariant: oh=%b vld=%b (need <=1 hot and vld==|oh)", oh, VLD);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [6:0] expOh,
                             input logic expVld, input int expChg);
    checks++;
    if (oh !== expOh || VLD !== expVld || chgSeen != expChg) begin
      errors++;
      $display("[TB] FAIL %s: got oh=%b vld=%b chg=%0d expected oh=%b vld=%b chg=%0d",
               name, oh, VLD, chgSeen, expOh, expVld, expChg);
    end
  endtask

  task automatic runVector(input vec_t v, input int idx);
    vec_t e;
    applyStimulus(v.code);
    sbQ.push_back(v);
    chgSeen = 0;
    repeat (v.hold) stepCycle();
    e = sbQ.pop_front();
    checkOutput($sformatf("vec%0d code=%b", idx, e.code), e.expOh, e.expVld, e.expChg);
  endtask

  function automatic vec_t mk(input logic [2:0] c, input int h, input logic [6:0] o,
                              input logic v, input int ch);
    vec_t r;
    r.code = c; r.hold = h; r.expOh = o; r.expVld = v; r.expChg = ch;
    return r;
  endfunction

  initial begin
    vec_t v;
    // Vector table: starts from accepted code 011 (C).
    vecs.push_back(mk(3'b101, 3, OH_C, 1'b1, 0));
    vecs.push_back(mk(3'b011, 10, OH_C, 1'b1, 0));
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(3'b111, 2, OH_C, 1'b1, 0));
      vecs.push_back(mk(3'b110, 2, OH_C, 1'b1, 0));
    end
    vecs.push_back(mk(3'b111, 6, OH_G, 1'b1, 1));
    vecs.push_back(mk(3'b111, 4, OH_G, 1'b1, 0));
    vecs.push_back(mk(3'b001, 8, OH_A, 1'b1, 1));

    rst = 1'b1;
    CLR = 1'b0;
    applyStimulus(3'b000);
    repeat (3) stepCycle();
    chgSeen = 0;
    checkOutput("reset state", OH_NONE, 1'b0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    v = mk(3'b000, 12, OH_NONE, 1'b0, 0);
    runVector(v, 0);

    // Exact latency for 011: unchanged through edge 5, C on edge 6, CHG one cycle.
    applyStimulus(3'b011);
    chgSeen = 0;
    repeat (5) stepCycle();
    checkOutput("latency edge5", OH_NONE, 1'b0, 0);
    stepCycle();
    checkOutput("latency edge6", OH_C, 1'b1, 1);
    checkBit("chg on edge6", CHG, 1'b1);
    stepCycle();
    checkBit("chg off edge7", CHG, 1'b0);

    foreach (vecs[i]) runVector(vecs[i], i + 1);

    // Reset while qualifying 100: immediate clear, then D after release.
    applyStimulus(3'b100);
    repeat (4) stepCycle();
    rst = 1'b1;
    #1;
    chgSeen = 0;
    checkOutput("reset mid-qual", OH_NONE, 1'b0, 0);
    checkBit("chg in reset", CHG, 1'b0);
    rst = 1'b0;
    chgSeen = 0;
    repeat (8) stepCycle();
    checkOutput("after reset 100", OH_D, 1'b1, 1);

    v = mk(3'b010, 8, OH_B, 1'b1, 1);
    runVector(v, 100);

`ifdef CODEC_HOLD_EN
    applyStimulus(3'b000);
    chgSeen = 0;
    repeat (20) stepCycle();
    checkOutput("hold 000", OH_B, 1'b1, 0);
    CLR = 1'b1;
    chgSeen = 0;
    stepCycle();
    CLR = 1'b0;
    checkOutput("clr clears", OH_NONE, 1'b0, 1);
    checkBit("clr chg pulse", CHG, 1'b1);
    stepCycle();
    checkBit("clr chg end", CHG, 1'b0);
    checkOutput("after clr", OH_NONE, 1'b0, 1);
`else
    CLR = 1'b1;
    chgSeen = 0;
    stepCycle();
    CLR = 1'b0;
    stepCycle();
    checkOutput("clr ignored", OH_B, 1'b1, 0);
    applyStimulus(3'b000);
    chgSeen = 0;
    repeat (5) stepCycle();
    checkOutput("000 edge5", OH_B, 1'b1, 0);
    stepCycle();
    checkOutput("000 edge6", OH_NONE, 1'b0, 1);
    repeat (14) stepCycle();
    checkOutput("000 held", OH_NONE, 1'b0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
